// File: rtl/call_stack_pkg.sv
// Shared CPU package: default stack geometry and the {push,pop} operation encoding.
package call_stack_pkg;

    localparam int CS_AW    = 10;
    localparam int CS_DEPTH = 16;

    // Encoding is exactly {push, pop}, so a strobe pair casts straight to an op.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } stack_op_t;

endpackage

// File: rtl/call_stack_if.sv
// Push/pop interface between the control unit (master) and the return stack (slave).
interface call_stack_if
    import call_stack_pkg::*;
#(
    parameter int AW    = CS_AW,
    parameter int DEPTH = CS_DEPTH
);
    logic                       push;
    logic                       pop;
    logic [AW-1:0]              ret_addr;
    logic [AW-1:0]              top;
    logic                       empty;
    logic                       full;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output push, pop, ret_addr,
        input  top, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, ret_addr,
        output top, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/call_stack_regfile.sv
// DEPTH x AW entry storage: one synchronous write port, one asynchronous read port.
module stack_regfile #(
    parameter int AW    = 10,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [AW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [AW-1:0]            o_rdata
);
    logic [AW-1:0] r_mem [DEPTH];

    // Entries are never cleared; count alone decides which ones are meaningful.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack: holds count and sticky flags, decodes the
// CALL/RET strobes and drives the top-of-stack entry to the PC mux.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int AW    = CS_AW,
    parameter int DEPTH = CS_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    call_stack_if.slave   stk
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    stack_op_t     w_op;
    logic          w_empty;
    logic          w_full;
    logic [IW-1:0] w_top_idx;
    logic [AW-1:0] w_rdata;
    logic          w_we;
    logic          w_wr_en;
    logic [IW-1:0] w_waddr;
    logic [CW-1:0] w_count_nxt;
    logic          w_ovf_nxt;
    logic          w_unf_nxt;

    assign w_op      = stack_op_t'({stk.push, stk.pop});
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    // When full the low bits wrap to 0, and 0 - 1 lands on DEPTH-1: the top entry.
    assign w_top_idx = r_count[IW-1:0] - IDX_ONE;

    // Next-state decode of the strobe pair against the current fill level.
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_count[IW-1:0];
        w_count_nxt = r_count;
        w_ovf_nxt   = r_overflow;
        w_unf_nxt   = r_underflow;
        unique case (w_op)
            OP_IDLE: ;
            OP_PUSH: begin
                if (w_full) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_we        = 1'b1;
                    w_count_nxt = r_count + CNT_ONE;
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    w_unf_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_count - CNT_ONE;
                end
            end
            OP_REPL: begin
                w_we = 1'b1;
                if (w_empty) begin
                    w_waddr     = '0;
                    w_count_nxt = CNT_ONE;
                    w_unf_nxt   = 1'b1;
                end else begin
                    w_waddr = w_top_idx;
                end
            end
            default: ;
        endcase
    end

    // Reset takes priority over a coincident strobe, including the entry write.
    assign w_wr_en = w_we & reset;

    // Fill level and sticky error flags; flags clear only on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_overflow  <= w_ovf_nxt;
            r_underflow <= w_unf_nxt;
        end
    end

    stack_regfile #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_regfile (
        .i_clk   (clk),
        .i_we    (w_wr_en),
        .i_waddr (w_waddr),
        .i_wdata (stk.ret_addr),
        .i_raddr (w_top_idx),
        .o_rdata (w_rdata)
    );

    assign stk.top       = w_empty ? '0 : w_rdata;
    assign stk.empty     = w_empty;
    assign stk.full      = w_full;
    assign stk.count     = r_count;
    assign stk.overflow  = r_overflow;
    assign stk.underflow = r_underflow;
endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: directed scenarios followed by random strobes, all
// compared against a queue-based model of a saturating LIFO.
module tb_call_stack;
    import call_stack_pkg::*;

    localparam int AW    = CS_AW;
    localparam int DEPTH = CS_DEPTH;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    call_stack_if #(.AW(AW), .DEPTH(DEPTH)) stk ();

    call_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .stk   (stk)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [AW-1:0] m_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [AW-1:0] m_top();
        return (m_q.size() > 0) ? m_q[$] : '0;
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".count"},     32'(stk.count),     32'(m_q.size()));
        check({tag, ".top"},       32'(stk.top),       32'(m_top()));
        check({tag, ".empty"},     32'(stk.empty),     32'(m_q.size() == 0));
        check({tag, ".full"},      32'(stk.full),      32'(m_q.size() == DEPTH));
        check({tag, ".overflow"},  32'(stk.overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(stk.underflow), 32'(m_unf));
    endtask

    // One clock: drive strobes, check top in-cycle (the RET target), clock, update model, check all.
    task automatic cyc(input string tag, input logic rst_n, input logic p, input logic o, input logic [AW-1:0] a);
        reset        = rst_n;
        stk.push     = p;
        stk.pop      = o;
        stk.ret_addr = a;
        #3;
        check({tag, ".top_in_cycle"}, 32'(stk.top), 32'(m_top()));
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (p && !o) begin
            if (m_q.size() < DEPTH) m_q.push_back(a);
            else                    m_ovf = 1'b1;
        end else if (o && !p) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else                m_unf = 1'b1;
        end else if (p && o) begin
            if (m_q.size() > 0) m_q[m_q.size()-1] = a;
            else begin
                m_q.push_back(a);
                m_unf = 1'b1;
            end
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        stk.push     = 1'b0;
        stk.pop      = 1'b0;
        stk.ret_addr = '0;
        @(negedge clk);

        // Reset then idle
        cyc("rst0", 1'b0, 1'b0, 1'b0, '0);
        cyc("rst1", 1'b0, 1'b0, 1'b0, '0);
        cyc("idle", 1'b1, 1'b0, 1'b0, '0);

        // Nested calls and returns
        cyc("call1", 1'b1, 1'b1, 1'b0, 10'h010);
        cyc("call2", 1'b1, 1'b1, 1'b0, 10'h020);
        cyc("call3", 1'b1, 1'b1, 1'b0, 10'h030);
        for (int i = 0; i < 3; i++) cyc("ret", 1'b1, 1'b0, 1'b1, '0);

        // Overflow: 17 pushes, then drain 16
        for (int i = 0; i <= DEPTH; i++) cyc("ovf_push", 1'b1, 1'b1, 1'b0, AW'(10'h100 + i));
        for (int i = 0; i < DEPTH; i++) cyc("ovf_pop", 1'b1, 1'b0, 1'b1, '0);

        // Underflow from reset
        cyc("unf_rst", 1'b0, 1'b0, 1'b0, '0);
        cyc("unf_pop", 1'b1, 1'b0, 1'b1, '0);
        cyc("unf_push", 1'b1, 1'b1, 1'b0, 10'h055);

        // Simultaneous push and pop
        cyc("repl_rst", 1'b0, 1'b0, 1'b0, '0);
        cyc("repl_a", 1'b1, 1'b1, 1'b0, 10'h011);
        cyc("repl_b", 1'b1, 1'b1, 1'b0, 10'h022);
        cyc("repl", 1'b1, 1'b1, 1'b1, 10'h3FF);
        cyc("repl_pop", 1'b1, 1'b0, 1'b1, '0);
        cyc("repl_pop2", 1'b1, 1'b0, 1'b1, '0);
        cyc("repl_empty", 1'b1, 1'b1, 1'b1, 10'h1A5);

        // Reset mid-operation with a coincident push
        cyc("mid_rst", 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cyc("mid_fill", 1'b1, 1'b1, 1'b0, AW'(10'h200 + i));
        cyc("mid_rst_push", 1'b0, 1'b1, 1'b0, 10'h2AA);
        cyc("mid_pop", 1'b1, 1'b0, 1'b1, '0);

        // Random phases biased toward pushes or pops to reach both boundaries
        for (int ph = 0; ph < 12; ph++) begin
            int bias = (ph % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 40; i++) begin
                int r = int'($urandom_range(99));
                logic rn = ($urandom_range(127) != 0);
                logic p, o;
                p = (r < bias);
                o = ($urandom_range(99) >= bias) || ($urandom_range(9) == 0);
                cyc("rand", rn, p, o, AW'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end expected end of stimulus");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware return-address stack that consumes the push/pop strobes from the control unit's CALL/RET decode.
- On CALL it stores the return address, the PC value after the call.
- On RET it supplies the saved address to the PC next-address mux.
- Sits beside the program counter; it is the memory end of the push/pop interface.

Parameters:
AW, 10, width of a program address in bits
DEPTH, 16, number of stack entries (power of two, >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
push  input  1  from control unit; store ret_addr this cycle
pop  input  1  from control unit; discard top entry this cycle
ret_addr  input  AW  return address to save (PC+1 of the CALL)
top  output  AW  current top-of-stack entry, valid combinationally; feeds PC mux on RET
empty  output  1  stack holds zero entries
full  output  1  stack holds DEPTH entries
count  output  $clog2(DEPTH)+1  number of valid entries
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset, sampled at clk edge while reset==0:
  - count=0, empty=1, full=0, overflow=0, underflow=0, top=0.
  - Entry contents need not be cleared.
- Stack pointer sp = count. Entries are held in a register array indexed 0..DEPTH-1. top = mem[count-1] when count>0, else 0.
- Read latency 0: top reflects the current registered state. A RET in cycle N uses top as the jump target in cycle N, and the pop takes effect at the end of cycle N.
- Write latency 1: after a push at edge N, top==ret_addr from cycle N+1.
- Per-edge actions, with reset deasserted:
  - idle (push=0, pop=0): no change.
  - push only, not full: mem[count]<=ret_addr, count<=count+1.
  - push only, full: no write, count unchanged, overflow<=1. The oldest entries are preserved and the new address is dropped.
  - pop only, not empty: count<=count-1. Memory is unchanged.
  - pop only, empty: count unchanged, underflow<=1. top stays 0.
  - push and pop, not empty: replace top. mem[count-1]<=ret_addr, count unchanged, no flags.
  - push and pop, empty: treated as push only. Write mem[0], count=1, underflow<=1.
- empty = (count==0); full = (count==DEPTH). Both are derived combinationally from count.
- count never wraps. The saturation rules above are the only boundary behaviour.
- overflow and underflow clear only on reset.
- Reset mid-operation: reset wins over any simultaneous push or pop. No write occurs that cycle.
- ret_addr is AW bits, stored unmodified. No arithmetic is performed inside the block.
- Inputs are assumed stable around the edge. No handshake exists: the control unit strobes are single-cycle, one per instruction.

Decomposition:
- Shared CPU package:
  - AW default constant.
  - DEPTH default constant.
  - Stack operation encoding: OP_IDLE, OP_PUSH, OP_POP, OP_REPL = {push,pop}. Used by both the control unit and this block's next-state logic.
- One natural sub-module: stack_regfile.
  - DEPTH x AW register array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
- call_stack holds count, the flags and the op decode, and instantiates stack_regfile.

Test Plan:
1. Reset then idle: hold reset=0 for 2 cycles, release -> count=0, empty=1, full=0, top=0, overflow=0, underflow=0.
2. Nested calls: push 0x010, 0x020, 0x030 on consecutive cycles -> count=3, top=0x030. Then pop each cycle -> top reads 0x030, 0x020, 0x010 in the pop cycles, then empty=1, top=0.
3. Overflow: push 0x100+i for i=0..16 (17 pushes, DEPTH=16) -> full=1 after the 16th, overflow=1 after the 17th, top=0x10F, count=16. Then 16 pops return 0x10F..0x100 in order.
4. Underflow: from reset, pop once -> underflow=1, count=0, top=0. Then push 0x055 -> top=0x055, underflow still 1.
5. Simultaneous push and pop: with stack [0x011,0x022], assert push=pop=1 with ret_addr=0x3FF -> count stays 2, top=0x3FF, next pop shows 0x011. Repeat with the stack empty -> count=1, top=ret_addr, underflow=1.
6. Reset mid-operation: with count=5, assert reset=0 together with push=1 -> next cycle count=0, empty=1, flags clear, no entry written (a subsequent pop underflows).
